multi_osc_bank: RTL and testbench

//  N-channel programmable divider/oscillator bank; each channel free-runs 0..max and wraps.

---
 rtl/sass_osc_pkg.sv | 15 +
 rtl/osc_channel.sv | 68 ++++++
 rtl/multi_osc_bank.sv | 44 ++++
 tb/tb_multi_osc_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sass_osc_pkg.sv
// Shared constants and channel state layout for the oscillator bank.
// Channel logic declares a width-matched copy of this layout for non-default CNT_W.
package sass_osc_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 19;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_CNT_W-1:0] active_max;
        logic [DEF_CNT_W-1:0] pending_max;
        logic                 square;
    } osc_ch_state_t;

endpackage

// File: rtl/osc_channel.sv
// One free-running divider channel: counter, active/pending terminal count,
// wrap tick and square toggle.
module osc_channel
    import sass_osc_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_max,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             square
);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] active_max;
        logic [CNT_W-1:0] pending_max;
        logic             square;
    } ch_state_t;

    ch_state_t        state_reg, state_next;
    logic             tick_reg, tick_next;
    logic [CNT_W-1:0] load_max;

    always_comb begin
        state_next = state_reg;
        tick_next  = 1'b0;
        // A write landing in the same cycle as a reload wins over the stored pending value.
        load_max   = wr ? wr_max : state_reg.pending_max;
        state_next.pending_max = load_max;
        if (sync) begin
            state_next.count      = '0;
            state_next.square     = 1'b0;
            state_next.active_max = load_max;
        end else if (!en) begin
            if (wr) begin
                state_next.active_max = wr_max;
            end
        end else if (state_reg.count >= state_reg.active_max) begin
            state_next.count      = '0;
            state_next.square     = ~state_reg.square;
            state_next.active_max = load_max;
            tick_next             = 1'b1;
        end else begin
            state_next.count = state_reg.count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
        end
    end

    assign count  = state_reg.count;
    assign tick   = tick_reg;
    assign square = state_reg.square;

endmodule

// File: rtl/multi_osc_bank.sv
// Bank of independent divider/oscillator channels sharing one divider write port.
module multi_osc_bank
    import sass_osc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       sync,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [CNT_W-1:0]        wr_max,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       square
);

    logic [NUM_CH-1:0] ch_wr;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Addresses at or above NUM_CH never match any channel, so those writes drop.
            assign ch_wr[gi] = wr_en && (32'(wr_ch) == gi);

            osc_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .en     (en[gi]),
                .sync   (sync[gi]),
                .wr     (ch_wr[gi]),
                .wr_max (wr_max),
                .count  (count[gi*CNT_W +: CNT_W]),
                .tick   (tick[gi]),
                .square (square[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_osc_bank.sv
// Directed bench for the oscillator bank: a 4-channel instance for the main scenarios
// and a 3-channel instance for out-of-range writes and mid-run reset.
module tb_multi_osc_bank;

    localparam int CW = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    en, sync;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_max;
    logic [4*CW-1:0] count;
    logic [3:0]    tick, square;

    logic          rst3;
    logic [2:0]    en3, sync3;
    logic          wr_en3;
    logic [1:0]    wr_ch3;
    logic [CW-1:0] wr_max3;
    logic [3*CW-1:0] count3;
    logic [2:0]    tick3, square3;

    int checks = 0;
    int fails  = 0;

    multi_osc_bank #(.NUM_CH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_max(wr_max), .count(count), .tick(tick), .square(square)
    );

    multi_osc_bank #(.NUM_CH(3), .CNT_W(CW)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .sync(sync3), .wr_en(wr_en3), .wr_ch(wr_ch3),
        .wr_max(wr_max3), .count(count3), .tick(tick3), .square(square3)
    );

    function automatic logic [CW-1:0] cnt(input int ch);
        return count[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] cnt3(input int ch);
        return count3[ch*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int ch, input int mx);
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_max = CW'(mx);
        step();
        wr_en  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0; sync = '0; wr_en = 1'b0; wr_ch = '0; wr_max = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (count !== '0 || tick !== 4'b0 || square !== 4'b0) begin
            fails++;
            $display("FAIL reset: count=%h tick=%b square=%b, required all zero", count, tick, square);
        end
        $display("test_reset: count=%h tick=%b square=%b", count, tick, square);
    endtask

    task automatic test_basic_period();
        logic [CW-1:0] exp_c;
        logic exp_t, exp_s;
        write(0, 3);
        en[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_c = CW'(k % 4);
            exp_t = (k % 4 == 0);
            exp_s = (k >= 4 && k < 8);
            checks++;
            if (cnt(0) !== exp_c || tick[0] !== exp_t || square[0] !== exp_s) begin
                fails++;
                $display("FAIL basic_period k=%0d: count=%0d tick=%b sq=%b, required %0d %b %b",
                         k, cnt(0), tick[0], square[0], exp_c, exp_t, exp_s);
            end
            $display("basic_period k=%0d: count=%0d tick=%b sq=%b", k, cnt(0), tick[0], square[0]);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_deferred_load();
        int exp_c[7] = '{7, 8, 9, 0, 1, 2, 0};
        write(1, 9);
        en[1] = 1'b1;
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (cnt(1) !== CW'(5)) begin
            fails++;
            $display("FAIL deferred_setup: count=%0d, required 5", cnt(1));
        end
        write(1, 2);
        checks++;
        if (cnt(1) !== CW'(6)) begin
            fails++;
            $display("FAIL deferred_write: count=%0d, required 6", cnt(1));
        end
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (cnt(1) !== CW'(exp_c[k]) || tick[1] !== (exp_c[k] == 0)) begin
                fails++;
                $display("FAIL deferred k=%0d: count=%0d tick=%b, required %0d %b",
                         k, cnt(1), tick[1], exp_c[k], exp_c[k] == 0);
            end
            $display("deferred k=%0d: count=%0d tick=%b", k, cnt(1), tick[1]);
        end
        en[1] = 1'b0;
    endtask

    task automatic test_immediate_load();
        write(2, 9);
        en[2] = 1'b1;
        for (int k = 0; k < 7; k++) step();
        en[2] = 1'b0;
        write(2, 4);
        checks++;
        if (cnt(2) !== CW'(7) || tick[2] !== 1'b0) begin
            fails++;
            $display("FAIL immediate_hold: count=%0d tick=%b, required 7 0", cnt(2), tick[2]);
        end
        en[2] = 1'b1;
        step();
        checks++;
        if (cnt(2) !== '0 || tick[2] !== 1'b1 || square[2] !== 1'b1) begin
            fails++;
            $display("FAIL immediate_wrap: count=%0d tick=%b sq=%b, required 0 1 1",
                     cnt(2), tick[2], square[2]);
        end
        $display("immediate_load: count=%0d tick=%b sq=%b", cnt(2), tick[2], square[2]);
        en[2] = 1'b0;
    endtask

    task automatic test_sync_write();
        int  exp_c[4] = '{1, 0, 1, 0};
        logic exp_s[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        sync[0] = 1'b1;
        write(0, 5);
        sync[0] = 1'b0;
        en[0] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (cnt(0) !== CW'(4) || square[0] !== 1'b1) begin
            fails++;
            $display("FAIL sync_setup: count=%0d sq=%b, required 4 1", cnt(0), square[0]);
        end
        sync[0] = 1'b1;
        write(0, 1);
        sync[0] = 1'b0;
        checks++;
        if (cnt(0) !== '0 || square[0] !== 1'b0 || tick[0] !== 1'b0) begin
            fails++;
            $display("FAIL sync_hit: count=%0d sq=%b tick=%b, required 0 0 0",
                     cnt(0), square[0], tick[0]);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (cnt(0) !== CW'(exp_c[k]) || tick[0] !== (exp_c[k] == 0) || square[0] !== exp_s[k]) begin
                fails++;
                $display("FAIL sync_period k=%0d: count=%0d tick=%b sq=%b, required %0d %b %b",
                         k, cnt(0), tick[0], square[0], exp_c[k], exp_c[k] == 0, exp_s[k]);
            end
            $display("sync_period k=%0d: count=%0d tick=%b sq=%b", k, cnt(0), tick[0], square[0]);
        end
        en[0] = 1'b0;
    endtask

    task automatic test_max_zero();
        write(3, 0);
        en[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (cnt(3) !== '0 || tick[3] !== 1'b1 || square[3] !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL max_zero k=%0d: count=%0d tick=%b sq=%b, required 0 1 %b",
                         k, cnt(3), tick[3], square[3], k % 2 == 1);
            end
            $display("max_zero k=%0d: count=%0d tick=%b sq=%b", k, cnt(3), tick[3], square[3]);
        end
        en[3] = 1'b0;
    endtask

    task automatic test_three_channel();
        rst3 = 1'b1; en3 = '0; sync3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_max3 = '0;
        step();
        rst3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wr_en3  = 1'b1;
            wr_ch3  = 2'(c);
            wr_max3 = (c == 3) ? CW'(1) : CW'(5);
            step();
        end
        wr_en3 = 1'b0;
        en3 = 3'b111;
        for (int k = 0; k < 3; k++) step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (cnt3(c) !== CW'(3) || tick3[c] !== 1'b0) begin
                fails++;
                $display("FAIL bad_addr ch%0d: count=%0d tick=%b, required 3 0", c, cnt3(c), tick3[c]);
            end
            $display("bad_addr ch%0d: count=%0d", c, cnt3(c));
        end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (count3 !== '0 || tick3 !== 3'b111 || square3 !== 3'b111) begin
            fails++;
            $display("FAIL three_wrap: count=%h tick=%b sq=%b, required 0 111 111", count3, tick3, square3);
        end
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        checks++;
        if (count3 !== '0 || tick3 !== 3'b000 || square3 !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset: count=%h tick=%b sq=%b, required all zero", count3, tick3, square3);
        end
        step();
        checks++;
        if (count3 !== '0 || tick3 !== 3'b111 || square3 !== 3'b111) begin
            fails++;
            $display("FAIL post_reset_max0: count=%h tick=%b sq=%b, required 0 111 111",
                     count3, tick3, square3);
        end
        $display("three_channel: count=%h tick=%b sq=%b", count3, tick3, square3);
    endtask

    initial begin
        rst3 = 1'b1; en3 = '0; sync3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_max3 = '0;
        test_reset();
        test_basic_period();
        test_deferred_load();
        test_immediate_load();
        test_sync_write();
        test_max_zero();
        test_three_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
